// File: rtl/sevenseg_pkg.sv
// ---------------------------------------------------------------
// sevenseg_pkg : font table and blank pattern, active-low {g..a}
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

package sevenseg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] FONT_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

`default_nettype wire

// File: rtl/sevenseg_font.sv
// ---------------------------------------------------------------
// sevenseg_font : combinational hex-to-7-segment decoder
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module sevenseg_font
  import sevenseg_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg
);

  assign seg = FONT_TABLE[code];

endmodule

`default_nettype wire

// File: rtl/sevenseg_mux_param.sv
// ---------------------------------------------------------------
// sevenseg_mux_param : multiplexed N-digit display driver with
// frame-synchronous update, LZS, blink and PWM brightness. Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module sevenseg_mux_param
  import sevenseg_pkg::*;
#(
  parameter int N_DIG   = 8,
  parameter int DIV_W   = 16,
  parameter int BLINK_W = 24
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [4*N_DIG-1:0] digits,
  input  logic [N_DIG-1:0]   dp_in,
  input  logic [N_DIG-1:0]   blank_mask,
  input  logic [N_DIG-1:0]   blink_mask,
  input  logic               lzs,
  input  logic [3:0]         brightness,
  input  logic               upd,
  output logic               upd_pend,
  output logic               frame_tick,
  output logic [N_DIG-1:0]   an,
  output logic [6:0]         seg,
  output logic               dp
);

  localparam int IDX_W = $clog2(N_DIG);

  logic [DIV_W-1:0]   div;
  logic [IDX_W-1:0]   idx;
  logic [BLINK_W-1:0] blink;

  logic [4*N_DIG-1:0] pend_digits, act_digits;
  logic [N_DIG-1:0]   pend_dp,     act_dp;
  logic [N_DIG-1:0]   pend_blank,  act_blank;
  logic [N_DIG-1:0]   pend_blink,  act_blink;
  logic               pend_lzs,    act_lzs;

  logic               wrap;
  logic [3:0]         cur_code;
  logic [6:0]         font_seg;
  logic [N_DIG-1:0]   suppressed;
  logic               zero_run;
  logic               pwm_open;
  logic               lit;

  assign wrap = (&div) && (idx == IDX_W'(N_DIG - 1));

  // Scan timing, frame-aligned commit of pending data and the update handshake
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div         <= '0;
      idx         <= '0;
      blink       <= '0;
      frame_tick  <= 1'b0;
      upd_pend    <= 1'b0;
      pend_digits <= '0;
      pend_dp     <= '0;
      pend_blank  <= '0;
      pend_blink  <= '0;
      pend_lzs    <= 1'b0;
      act_digits  <= '0;
      act_dp      <= '0;
      act_blank   <= '0;
      act_blink   <= '0;
      act_lzs     <= 1'b0;
    end else begin
      div        <= div + 1'b1;
      blink      <= blink + 1'b1;
      frame_tick <= wrap;
      if (&div) begin
        idx <= wrap ? '0 : idx + 1'b1;
      end
      if (wrap && upd_pend) begin
        act_digits <= pend_digits;
        act_dp     <= pend_dp;
        act_blank  <= pend_blank;
        act_blink  <= pend_blink;
        act_lzs    <= pend_lzs;
      end
      if (upd) begin
        pend_digits <= digits;
        pend_dp     <= dp_in;
        pend_blank  <= blank_mask;
        pend_blink  <= blink_mask;
        pend_lzs    <= lzs;
        upd_pend    <= 1'b1;
      end else if (wrap) begin
        upd_pend <= 1'b0;
      end
    end
  end

  // Walk down from the top digit; digit 0 is never part of the leading-zero run
  always_comb begin
    suppressed = '0;
    zero_run   = act_lzs;
    for (int i = N_DIG - 1; i >= 1; i--) begin
      zero_run      = zero_run && (act_digits[4*i +: 4] == 4'h0);
      suppressed[i] = zero_run;
    end
  end

  assign cur_code = act_digits[4*idx +: 4];
  assign pwm_open = (brightness == 4'hF) || (div[DIV_W-1 -: 4] < brightness);
  assign lit      = !act_blank[idx] && !suppressed[idx]
                 && !(blink[BLINK_W-1] && act_blink[idx]) && pwm_open;

  sevenseg_font u_font (
    .code (cur_code),
    .seg  (font_seg)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an  <= '1;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else if (lit) begin
      an  <= ~(N_DIG'(1) << idx);
      seg <= font_seg;
      dp  <= ~act_dp[idx];
    end else begin
      an  <= '1;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sevenseg_mux_param.sv
// ---------------------------------------------------------------
// tb_sevenseg_mux_param : randomized + directed bench, N_DIG=4,
// DIV_W=5, BLINK_W=8, checked against a time-based model. Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module tb_sevenseg_mux_param;

  localparam int ND = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [15:0]   digits = '0;
  logic [3:0]    dp_in = '0, blank_mask = '0, blink_mask = '0;
  logic          lzs = 1'b0, upd = 1'b0;
  logic [3:0]    brightness = 4'hF;
  logic          upd_pend, frame_tick, dp;
  logic [3:0]    an;
  logic [6:0]    seg;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  sevenseg_mux_param #(.N_DIG(4), .DIV_W(5), .BLINK_W(8)) dut (
    .clk(clk), .reset(reset), .digits(digits), .dp_in(dp_in),
    .blank_mask(blank_mask), .blink_mask(blink_mask), .lzs(lzs),
    .brightness(brightness), .upd(upd), .upd_pend(upd_pend),
    .frame_tick(frame_tick), .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] glyph(input logic [3:0] c);
    case (c)
      4'h0: glyph = 7'h40;  4'h1: glyph = 7'h79;  4'h2: glyph = 7'h24;  4'h3: glyph = 7'h30;
      4'h4: glyph = 7'h19;  4'h5: glyph = 7'h12;  4'h6: glyph = 7'h02;  4'h7: glyph = 7'h78;
      4'h8: glyph = 7'h00;  4'h9: glyph = 7'h10;  4'hA: glyph = 7'h08;  4'hB: glyph = 7'h03;
      4'hC: glyph = 7'h46;  4'hD: glyph = 7'h21;  4'hE: glyph = 7'h06;  default: glyph = 7'h0E;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: time since reset decides slot, PWM phase and blink phase
  int          t;
  logic [15:0] m_dig, p_dig;
  logic [3:0]  m_dp, m_blank, m_blink, p_dp, p_blank, p_blink;
  logic        m_lzs, p_lzs, m_pend;
  logic [3:0]  e_an = 4'hF;
  logic [6:0]  e_seg = 7'h7F;
  logic        e_dp = 1'b1, e_ft = 1'b0, e_up = 1'b0;

  always @(posedge clk or posedge reset) begin : model
    int  dv, ix;
    bit  on, lead, wrap;
    if (reset) begin
      t = 0; m_pend = 0;
      m_dig = '0; m_dp = '0; m_blank = '0; m_blink = '0; m_lzs = 0;
      p_dig = '0; p_dp = '0; p_blank = '0; p_blink = '0; p_lzs = 0;
      e_an = 4'hF; e_seg = 7'h7F; e_dp = 1; e_ft = 0; e_up = 0;
    end else begin
      dv = t % 32;
      ix = (t / 32) % ND;
      on = (brightness == 4'hF) || ((dv / 2) < int'(brightness));
      if (m_blank[ix]) on = 0;
      if ((t % 256) >= 128 && m_blink[ix]) on = 0;
      if (m_lzs && ix != 0) begin
        lead = 1;
        for (int d = ND - 1; d >= ix; d--) if (m_dig[4*d +: 4] != 0) lead = 0;
        if (lead) on = 0;
      end
      e_an  = on ? ~(4'b0001 << ix) : 4'hF;
      e_seg = on ? glyph(m_dig[4*ix +: 4]) : 7'h7F;
      e_dp  = on ? ~m_dp[ix] : 1'b1;
      wrap  = (dv == 31) && (ix == ND - 1);
      e_ft  = wrap;
      if (wrap && m_pend) begin
        m_dig = p_dig; m_dp = p_dp; m_blank = p_blank; m_blink = p_blink; m_lzs = p_lzs;
      end
      if (upd) begin
        p_dig = digits; p_dp = dp_in; p_blank = blank_mask; p_blink = blink_mask; p_lzs = lzs;
        m_pend = 1;
      end else if (wrap) begin
        m_pend = 0;
      end
      e_up = m_pend;
      t++;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("an", {28'd0, an}, {28'd0, e_an});
      chk("seg", {25'd0, seg}, {25'd0, e_seg});
      chk("dp", {31'd0, dp}, {31'd0, e_dp});
      chk("frame_tick", {31'd0, frame_tick}, {31'd0, e_ft});
      chk("upd_pend", {31'd0, upd_pend}, {31'd0, e_up});
    end
  end

  task automatic load(input logic [15:0] d, input logic [3:0] bl, input logic [3:0] bk,
                      input logic z);
    digits = d; dp_in = 4'h0; blank_mask = bl; blink_mask = bk; lzs = z;
    upd = 1'b1;
    @(negedge clk);
    upd = 1'b0;
  endtask

  task automatic wait_frame();
    int n = 0;
    @(negedge clk);
    while (!frame_tick && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("frame_tick_seen", {31'd0, frame_tick}, 32'd1);
  endtask

  // Called right after wait_frame: slot i of the new frame is inspected
  task automatic check_frame(input string tag, input logic [27:0] segs, input logic [3:0] litm);
    @(negedge clk);
    for (int i = 0; i < ND; i++) begin
      if (litm[i]) begin
        chk({tag, "_an"}, {28'd0, an}, {28'd0, ~(4'b0001 << i)});
        chk({tag, "_seg"}, {25'd0, seg}, {25'd0, segs[7*i +: 7]});
      end else begin
        chk({tag, "_dark"}, {28'd0, an}, 32'hF);
      end
      repeat (32) @(negedge clk);
    end
  endtask

  initial begin
    int cnt, cnt2;
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    cmp_en = 1'b1;
    chk("rst_an", {28'd0, an}, 32'hF);
    chk("rst_seg", {25'd0, seg}, 32'h7F);
    chk("rst_pend", {31'd0, upd_pend}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("first_frame_seg", {25'd0, seg}, 32'h40);

    wait_frame();
    load(16'h12AF, 4'h0, 4'h0, 1'b0);
    chk("upd_pend_set", {31'd0, upd_pend}, 32'd1);
    wait_frame();
    check_frame("hex12AF", {7'h79, 7'h24, 7'h08, 7'h0E}, 4'hF);

    load(16'h0005, 4'h0, 4'h0, 1'b1);
    wait_frame();
    check_frame("lzs0005", {7'h7F, 7'h7F, 7'h7F, 7'h12}, 4'b0001);
    load(16'h0000, 4'h0, 4'h0, 1'b1);
    wait_frame();
    check_frame("lzs0000", {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b0001);

    load(16'h8888, 4'h0, 4'h0, 1'b0);
    wait_frame();
    brightness = 4'd4;
    cnt = 0;
    repeat (128) begin @(negedge clk); if (an != 4'hF) cnt++; end
    chk("pwm4_lit_cycles", cnt, 32);
    brightness = 4'd0;
    @(negedge clk);
    cnt = 0;
    repeat (128) begin @(negedge clk); if (an != 4'hF) cnt++; end
    chk("pwm0_lit_cycles", cnt, 0);
    brightness = 4'hF;

    wait_frame();
    repeat (40) @(negedge clk);
    load(16'h1111, 4'h0, 4'h0, 1'b0);
    repeat (20) @(negedge clk);
    load(16'h2222, 4'h0, 4'h0, 1'b0);
    chk("overwrite_pend", {31'd0, upd_pend}, 32'd1);
    wait_frame();
    check_frame("over2222", {7'h24, 7'h24, 7'h24, 7'h24}, 4'hF);

    load(16'h8888, 4'h0, 4'b0010, 1'b0);
    wait_frame();
    @(negedge clk);
    cnt = 0; cnt2 = 0;
    repeat (512) begin
      @(negedge clk);
      if (an == 4'b1101) cnt++;
      if (an == 4'b1011) cnt2++;
    end
    chk("blink_digit1_cycles", cnt, 64);
    chk("blink_digit2_cycles", cnt2, 128);

    repeat (3000) begin
      if ($urandom_range(0, 49) == 0) begin
        for (int i = 0; i < ND; i++)
          digits[4*i +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
        dp_in = 4'($urandom); blank_mask = 4'($urandom & $urandom);
        blink_mask = 4'($urandom); lzs = 1'($urandom);
        upd = 1'b1;
      end else begin
        upd = 1'b0;
      end
      if ($urandom_range(0, 99) == 0) brightness = 4'($urandom);
      @(negedge clk);
    end
    upd = 1'b0;
    brightness = 4'hF;

    load(16'h9999, 4'h0, 4'h0, 1'b0);
    chk("pend_before_reset", {31'd0, upd_pend}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_an", {28'd0, an}, 32'hF);
    chk("async_rst_seg", {25'd0, seg}, 32'h7F);
    chk("async_rst_dp", {31'd0, dp}, 32'd1);
    chk("async_rst_pend", {31'd0, upd_pend}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_zero", {25'd0, seg}, 32'h40);
    wait_frame();
    check_frame("post_rst_frame", {7'h40, 7'h40, 7'h40, 7'h40}, 4'hF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
